// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the mem_core storage block.
//   - Default geometry (data width, word count, address width).
//   - Encoding of the wr_rd_i request select.
//   - State type for the reset/ready sequencer in mem_core.
// ---------------------------------------------------------------------------
package mem_pkg;

  localparam int MEM_WIDTH      = 16;
  localparam int MEM_DEPTH      = 16;
  localparam int MEM_ADDR_WIDTH = 4;

  localparam logic MEM_WRITE = 1'b1;
  localparam logic MEM_READ  = 1'b0;

  // ST_RESET is held while rst is low and for the edge that samples its
  // release; ST_READY is the steady accepting state.
  typedef enum logic {
    ST_RESET = 1'b0,
    ST_READY = 1'b1
  } memState_t;

endpackage

// File: rtl/mem_array.sv
// ---------------------------------------------------------------------------
// mem_array
// Register-file storage with asynchronous clear and a registered read port.
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low clear of every word and the read reg
//   i_wrEn       store i_wrData at i_addr on this edge
//   i_rdEn       load the read register on this edge
//   i_rdAddrOk   address is inside the array; when low a read loads zero
//   i_addr       word address
//   i_wrData     write data
//   o_rdData     registered read data, holds between reads
// ---------------------------------------------------------------------------
module mem_array #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wrEn,
  input  logic                  i_rdEn,
  input  logic                  i_rdAddrOk,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [WIDTH-1:0]      i_wrData,
  output logic [WIDTH-1:0]      o_rdData
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdData;

  // Every word is cleared on reset so reads after reset return zero
  // regardless of what was stored before.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wrEn) begin
      r_mem[i_addr] <= i_wrData;
    end
  end

  // Out-of-range reads are steered to zero here so the array is never
  // indexed past its last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdData <= '0;
    end else if (i_rdEn) begin
      if (i_rdAddrOk) begin
        r_rdData <= r_mem[i_addr];
      end else begin
        r_rdData <= '0;
      end
    end
  end

  assign o_rdData = r_rdData;

endmodule

// File: rtl/mem_core.sv
// ---------------------------------------------------------------------------
// mem_core
// Single-port synchronous memory with a valid/ready request handshake.
// A request is accepted on a rising edge where valid_i and ready_o are high.
// Writes store at the accepting edge; reads return data one cycle later.
// Addresses at or above DEPTH drop writes and read back as zero.
// DEPTH must not exceed 2**ADDR_WIDTH.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   wr_data_i  write data
//   addr_i     word address
//   wr_rd_i    1 = write, 0 = read
//   valid_i    request present
//   ready_o    block can accept a request (registered, reset-driven only)
//   rd_data_o  registered read data
// ---------------------------------------------------------------------------
module mem_core
  import mem_pkg::*;
#(
  parameter int WIDTH      = MEM_WIDTH,
  parameter int DEPTH      = MEM_DEPTH,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  wr_rd_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [WIDTH-1:0]      rd_data_o
);

  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
  localparam int                LP_DEPTH_INT = DEPTH;
  localparam logic [ADDR_WIDTH:0] LP_DEPTH   = LP_DEPTH_INT[ADDR_WIDTH:0];

  memState_t r_state;
  memState_t w_nextState;

  logic w_accept;
  logic w_addrOk;
  logic w_wrEn;
  logic w_rdEn;

  // Ready sequencer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Leave reset on the first edge that sees rst released, then stay ready
  // until the next reset.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_RESET: w_nextState = ST_READY;
      ST_READY: w_nextState = ST_READY;
    endcase
  end

  // ready_o comes straight from a flop so no input can reach it
  // combinationally.
  assign ready_o  = (r_state == ST_READY);

  assign w_accept = valid_i & ready_o;
  assign w_addrOk = ({1'b0, addr_i} < LP_DEPTH);
  assign w_wrEn   = w_accept & (wr_rd_i == MEM_WRITE) & w_addrOk;
  assign w_rdEn   = w_accept & (wr_rd_i == MEM_READ);

  mem_array #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_memArray (
    .clk        (clk),
    .rst_n      (rst),
    .i_wrEn     (w_wrEn),
    .i_rdEn     (w_rdEn),
    .i_rdAddrOk (w_addrOk),
    .i_addr     (addr_i),
    .i_wrData   (wr_data_i),
    .o_rdData   (rd_data_o)
  );

endmodule

// File: tb/tb_mem_core.sv
// ---------------------------------------------------------------------------
// tb_mem_core
// Drives a default-geometry mem_core and a DEPTH=12 mem_core from the same
// request stream. A behavioural model (plain arrays) predicts ready and read
// data for both; a compare process checks them every cycle, and the directed
// sequence adds hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_mem_core;
  import mem_pkg::*;

  logic        clk    = 1'b0;
  logic        rst    = 1'b0;
  logic [15:0] wrData = '0;
  logic [3:0]  addr   = '0;
  logic        wrRd   = 1'b0;
  logic        valid  = 1'b0;

  logic        ready16;
  logic        ready12;
  logic [15:0] rd16;
  logic [15:0] rd12;

  int compared   = 0;
  int mismatched = 0;

  // Model state: contents of both memories, the predicted read registers
  // and whether the block is accepting.
  logic [15:0] m16 [16];
  logic [15:0] m12 [16];
  logic [15:0] mRd16;
  logic [15:0] mRd12;
  logic        mReady;

  always #5 clk = ~clk;

  mem_core dut16 (
    .clk       (clk),
    .rst       (rst),
    .wr_data_i (wrData),
    .addr_i    (addr),
    .wr_rd_i   (wrRd),
    .valid_i   (valid),
    .ready_o   (ready16),
    .rd_data_o (rd16)
  );

  mem_core #(
    .WIDTH      (16),
    .DEPTH      (12),
    .ADDR_WIDTH (4)
  ) dut12 (
    .clk       (clk),
    .rst       (rst),
    .wr_data_i (wrData),
    .addr_i    (addr),
    .wr_rd_i   (wrRd),
    .valid_i   (valid),
    .ready_o   (ready12),
    .rd_data_o (rd12)
  );

  task automatic modelClear();
    for (int i = 0; i < 16; i++) begin
      m16[i] = '0;
      m12[i] = '0;
    end
    mRd16  = '0;
    mRd12  = '0;
    mReady = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic wr,
                               input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    valid  = v;
    wrRd   = wr;
    addr   = a;
    wrData = d;
  endtask

  // Behavioural model: an accepted write stores if the address exists,
  // an accepted read returns the stored word or zero if it does not.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      modelClear();
    end else begin
      if (valid && mReady) begin
        if (wrRd == MEM_WRITE) begin
          m16[addr] = wrData;
          if (addr < 12) m12[addr] = wrData;
        end else begin
          mRd16 = m16[addr];
          mRd12 = (addr < 12) ? m12[addr] : 16'h0000;
        end
      end
      mReady = 1'b1;
    end
  end

  // Every-cycle comparison against the model.
  always @(posedge clk) begin
    #2;
    checkOutput("ready16", {15'b0, ready16}, {15'b0, mReady});
    checkOutput("ready12", {15'b0, ready12}, {15'b0, mReady});
    checkOutput("rd16", rd16, mRd16);
    checkOutput("rd12", rd12, mRd12);
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelClear();

    // Reset held for two edges, then released.
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rstReady", {15'b0, ready16}, 16'h0000);
    checkOutput("rstRd", rd16, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2;
    checkOutput("relReady16", {15'b0, ready16}, 16'h0001);
    checkOutput("relReady12", {15'b0, ready12}, 16'h0001);

    // Write presented without valid must be ignored.
    applyStimulus(1'b0, MEM_WRITE, 4'd5, 16'hFFFF);
    applyStimulus(1'b1, MEM_READ, 4'd5, 16'h0000);
    @(posedge clk);
    #2;
    checkOutput("noValid", rd16, 16'h0000);

    // Write then read.
    applyStimulus(1'b1, MEM_WRITE, 4'd3, 16'hA5A5);
    applyStimulus(1'b1, MEM_READ, 4'd3, 16'h0000);
    @(posedge clk);
    #2;
    checkOutput("wrRd3", rd16, 16'hA5A5);

    // Full sweep, back-to-back writes then back-to-back reads.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, MEM_WRITE, 4'(i), 16'(i * 16'h11));
    end
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, MEM_READ, 4'(i), 16'h0000);
      @(posedge clk);
      #2;
      checkOutput("sweep16", rd16, 16'(i * 16'h11));
      checkOutput("sweep12", rd12, (i < 12) ? 16'(i * 16'h11) : 16'h0000);
    end

    // Out-of-range write/read on the 12-word instance.
    applyStimulus(1'b1, MEM_WRITE, 4'd13, 16'hBEEF);
    applyStimulus(1'b1, MEM_READ, 4'd13, 16'h0000);
    @(posedge clk);
    #2;
    checkOutput("oorRd12", rd12, 16'h0000);
    checkOutput("inRangeRd16", rd16, 16'hBEEF);
    applyStimulus(1'b1, MEM_READ, 4'd1, 16'h0000);
    @(posedge clk);
    #2;
    checkOutput("addr1Rd12", rd12, 16'h0011);

    // Async reset mid-burst.
    applyStimulus(1'b1, MEM_WRITE, 4'd7, 16'h1234);
    @(posedge clk);
    #3;
    rst   = 1'b0;
    valid = 1'b0;
    #1;
    checkOutput("asyncRd16", rd16, 16'h0000);
    checkOutput("asyncRd12", rd12, 16'h0000);
    checkOutput("asyncReady", {15'b0, ready16}, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    applyStimulus(1'b1, MEM_READ, 4'd7, 16'h0000);
    @(posedge clk);
    #2;
    checkOutput("postRstRd7", rd16, 16'h0000);

    applyStimulus(1'b0, MEM_READ, 4'd0, 16'h0000);
    repeat (2) @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
